// File: rtl/axi_datamover_pkg.sv
// Shared types and constants for the DataMover S2MM write controller:
// FSM states, response codes, status bit positions and command field layout.
package axi_datamover_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StData,
        StSts,
        StResp
    } wr_state_e;

    localparam logic [1:0] RespOkay   = 2'd0;
    localparam logic [1:0] RespSlverr = 2'd2;
    localparam logic [1:0] RespDecerr = 2'd3;

    localparam int unsigned StsOkayBit   = 7;
    localparam int unsigned StsSlverrBit = 6;
    localparam int unsigned StsDecerrBit = 5;
    localparam int unsigned StsInterrBit = 4;

    localparam int unsigned CmdRsvW = 4;
    localparam int unsigned CmdTagW = 4;
    localparam int unsigned CmdDsaW = 6;
    localparam int unsigned CmdBttW = 23;

    localparam logic CmdDrr      = 1'b0;
    localparam logic CmdEof      = 1'b1;
    localparam logic CmdTypeIncr = 1'b1;

    // Clean completion needs OKAY, no error flags and our own tag echoed back.
    function automatic logic [1:0] decode_sts(input logic [7:0] sts,
                                              input logic [CmdTagW-1:0] tag);
        logic w_err;
        w_err = sts[StsSlverrBit] | sts[StsDecerrBit] | sts[StsInterrBit];
        if (sts[StsOkayBit] && !w_err && (sts[CmdTagW-1:0] == tag)) begin
            return RespOkay;
        end else if (sts[StsDecerrBit]) begin
            return RespDecerr;
        end
        return RespSlverr;
    endfunction

endpackage

// File: rtl/axi_datamover_keep_gen.sv
// Latches the beat count and final-beat byte mask for a request and counts
// beats down as the stream handshakes.
module axi_datamover_keep_gen #(
    parameter int unsigned BYTES      = 8,
    parameter int unsigned SIZE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [SIZE_WIDTH-1:0] i_size,
    input  logic                  i_dec,
    output logic [SIZE_WIDTH-1:0] o_beats,
    output logic [BYTES-1:0]      o_last_keep
);
    localparam int unsigned ExtW = SIZE_WIDTH + 1;

    logic [ExtW-1:0]       w_size_ext;
    logic [ExtW-1:0]       w_beats;
    logic [ExtW-1:0]       w_rem;
    logic [BYTES-1:0]      w_keep;
    logic                  w_unused_beats_msb;
    logic [SIZE_WIDTH-1:0] r_beats;
    logic [BYTES-1:0]      r_keep;

    // One spare bit so size + BYTES-1 cannot wrap before the divide.
    assign w_size_ext = {1'b0, i_size};
    assign w_beats    = (w_size_ext + ExtW'(BYTES - 1)) / ExtW'(BYTES);
    assign w_rem      = w_size_ext % ExtW'(BYTES);
    assign w_unused_beats_msb = w_beats[SIZE_WIDTH];

    always_comb begin
        w_keep = '0;
        for (int b = 0; b < BYTES; b++) begin
            w_keep[b] = (w_rem == '0) || (ExtW'(b) < w_rem);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beats <= '0;
            r_keep  <= '0;
        end else if (i_load) begin
            r_beats <= w_beats[SIZE_WIDTH-1:0];
            r_keep  <= w_keep;
        end else if (i_dec && (r_beats != '0)) begin
            r_beats <= r_beats - SIZE_WIDTH'(1);
        end
    end

    assign o_beats     = r_beats;
    assign o_last_keep = r_keep;

endmodule

// File: rtl/axi_datamover_write_ctrl.sv
// DDR write request -> AXI DataMover S2MM command, stream and status bridge.
// Define DATAMOVER_WR_TIMEOUT_EN to add a status watchdog of TIMEOUT_CYCLES.
module axi_datamover_write_ctrl
    import axi_datamover_pkg::*;
#(
    parameter int unsigned S2MM_DATA_WIDTH = 64,
    parameter int unsigned S2MM_CMD_WIDTH  = 72,
    parameter int unsigned S2MM_ADDR_WIDTH = 32,
    parameter int unsigned S2MM_SIZE_WIDTH = 16,
    parameter int unsigned S2MM_STS_WIDTH  = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         ddr_wreq_ready,
    input  logic                         ddr_wreq_valid,
    input  logic [S2MM_ADDR_WIDTH-1:0]   ddr_wreq_addr,
    input  logic [S2MM_SIZE_WIDTH-1:0]   ddr_wreq_size,
    output logic                         ddr_wdata_ready,
    input  logic                         ddr_wdata_valid,
    input  logic [S2MM_DATA_WIDTH-1:0]   ddr_wdata,
    output logic                         ddr_wresp_valid,
    output logic [1:0]                   ddr_wresp,
    output logic [S2MM_CMD_WIDTH-1:0]    s2mm_cmd_tdata,
    output logic                         s2mm_cmd_tvalid,
    input  logic                         s2mm_cmd_tready,
    output logic [S2MM_DATA_WIDTH-1:0]   s2mm_tdata,
    output logic [S2MM_DATA_WIDTH/8-1:0] s2mm_tkeep,
    output logic                         s2mm_tlast,
    output logic                         s2mm_tvalid,
    input  logic                         s2mm_tready,
    input  logic [S2MM_STS_WIDTH-1:0]    s2mm_sts_tdata,
    input  logic [S2MM_STS_WIDTH/8-1:0]  s2mm_sts_tkeep,
    input  logic                         s2mm_sts_tlast,
    input  logic                         s2mm_sts_tvalid,
    output logic                         s2mm_sts_tready
);
    localparam int unsigned Bytes    = S2MM_DATA_WIDTH / 8;
    localparam int unsigned AlignW   = $clog2(Bytes);
    localparam int unsigned CmdFullW = S2MM_ADDR_WIDTH + CmdRsvW + CmdTagW + CmdDsaW + CmdBttW + 3;
    localparam logic [S2MM_ADDR_WIDTH-1:0] AddrMask =
        S2MM_ADDR_WIDTH'((64'd1 << AlignW) - 64'd1);

    wr_state_e                   r_state;
    logic                        r_wreq_ready;
    logic                        r_cmd_tvalid;
    logic [S2MM_CMD_WIDTH-1:0]   r_cmd_tdata;
    logic                        r_sts_tready;
    logic                        r_wresp_valid;
    logic [1:0]                  r_wresp;
    logic [CmdTagW-1:0]          r_tag;

    logic                        w_req_hs;
    logic                        w_in_data;
    logic                        w_data_hs;
    logic                        w_last_beat;
    logic                        w_sts_hs;
    logic [S2MM_SIZE_WIDTH-1:0]  w_beats;
    logic [Bytes-1:0]            w_last_keep;
    logic [CmdFullW-1:0]         w_cmd_full;
    logic                        w_unused_sts;

    assign w_req_hs    = ddr_wreq_valid & r_wreq_ready;
    assign w_in_data   = (r_state == StData);
    assign w_data_hs   = w_in_data & ddr_wdata_valid & s2mm_tready;
    assign w_last_beat = (w_beats == S2MM_SIZE_WIDTH'(1));
    assign w_sts_hs    = r_sts_tready & s2mm_sts_tvalid;
    assign w_unused_sts = ^{s2mm_sts_tkeep, s2mm_sts_tlast};

    assign w_cmd_full = {{CmdRsvW{1'b0}}, r_tag, ddr_wreq_addr & ~AddrMask, CmdDrr, CmdEof,
                         {CmdDsaW{1'b0}}, CmdTypeIncr, CmdBttW'(ddr_wreq_size)};

    axi_datamover_keep_gen #(
        .BYTES      (Bytes),
        .SIZE_WIDTH (S2MM_SIZE_WIDTH)
    ) u_keep_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_req_hs),
        .i_size      (ddr_wreq_size),
        .i_dec       (w_data_hs),
        .o_beats     (w_beats),
        .o_last_keep (w_last_keep)
    );

`ifdef DATAMOVER_WR_TIMEOUT_EN
    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TimeoutW-1:0] r_to_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_wreq_ready  <= 1'b0;
            r_cmd_tvalid  <= 1'b0;
            r_cmd_tdata   <= '0;
            r_sts_tready  <= 1'b0;
            r_wresp_valid <= 1'b0;
            r_wresp       <= RespOkay;
            r_tag         <= '0;
`ifdef DATAMOVER_WR_TIMEOUT_EN
            r_to_cnt      <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_wreq_ready <= 1'b1;
                    if (w_req_hs) begin
                        r_wreq_ready <= 1'b0;
                        r_cmd_tdata  <= S2MM_CMD_WIDTH'(w_cmd_full);
                        // Zero-length writes are refused without touching the DataMover.
                        if (ddr_wreq_size == '0) begin
                            r_state       <= StResp;
                            r_wresp_valid <= 1'b1;
                            r_wresp       <= RespSlverr;
                        end else begin
                            r_state      <= StCmd;
                            r_cmd_tvalid <= 1'b1;
                        end
                    end
                end
                StCmd: begin
                    if (s2mm_cmd_tready) begin
                        r_cmd_tvalid <= 1'b0;
                        r_state      <= StData;
                    end
                end
                StData: begin
                    if (w_data_hs && w_last_beat) begin
                        r_state      <= StSts;
                        r_sts_tready <= 1'b1;
`ifdef DATAMOVER_WR_TIMEOUT_EN
                        r_to_cnt     <= '0;
`endif
                    end
                end
                StSts: begin
                    if (w_sts_hs) begin
                        r_sts_tready  <= 1'b0;
                        r_wresp_valid <= 1'b1;
                        r_wresp       <= decode_sts(s2mm_sts_tdata[7:0], r_tag);
                        r_state       <= StResp;
                    end
`ifdef DATAMOVER_WR_TIMEOUT_EN
                    else if (r_to_cnt == TimeoutW'(TIMEOUT_CYCLES - 1)) begin
                        r_sts_tready  <= 1'b0;
                        r_wresp_valid <= 1'b1;
                        r_wresp       <= RespSlverr;
                        r_state       <= StResp;
                    end else begin
                        r_to_cnt <= r_to_cnt + TimeoutW'(1);
                    end
`endif
                end
                StResp: begin
                    r_wresp_valid <= 1'b0;
                    r_tag         <= r_tag + CmdTagW'(1);
                    r_wreq_ready  <= 1'b1;
                    r_state       <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign ddr_wreq_ready  = r_wreq_ready;
    assign s2mm_cmd_tvalid = r_cmd_tvalid;
    assign s2mm_cmd_tdata  = r_cmd_tdata;
    assign s2mm_sts_tready = r_sts_tready;
    assign ddr_wresp_valid = r_wresp_valid;
    assign ddr_wresp       = r_wresp;

    // Data phase is a straight wire-through; only keep/last are generated here.
    assign s2mm_tvalid     = w_in_data & ddr_wdata_valid;
    assign ddr_wdata_ready = w_in_data & s2mm_tready;
    assign s2mm_tdata      = w_in_data ? ddr_wdata : '0;
    assign s2mm_tlast      = w_in_data & w_last_beat;
    assign s2mm_tkeep      = !w_in_data ? '0 : (w_last_beat ? w_last_keep : '1);

endmodule

// File: tb/tb_axi_datamover_write_ctrl.sv
// Self-checking bench for axi_datamover_write_ctrl: transaction-level model plus
// directed literal checks; the watchdog test runs when DATAMOVER_WR_TIMEOUT_EN is defined.
module tb_axi_datamover_write_ctrl;
    localparam int DW = 64;
    localparam int BYTES = DW / 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ddr_wreq_ready, ddr_wreq_valid;
    logic [31:0]   ddr_wreq_addr;
    logic [15:0]   ddr_wreq_size;
    logic          ddr_wdata_ready, ddr_wdata_valid;
    logic [DW-1:0] ddr_wdata;
    logic          ddr_wresp_valid;
    logic [1:0]    ddr_wresp;
    logic [71:0]   s2mm_cmd_tdata;
    logic          s2mm_cmd_tvalid, s2mm_cmd_tready;
    logic [DW-1:0] s2mm_tdata;
    logic [BYTES-1:0] s2mm_tkeep;
    logic          s2mm_tlast, s2mm_tvalid, s2mm_tready;
    logic [7:0]    s2mm_sts_tdata;
    logic [0:0]    s2mm_sts_tkeep;
    logic          s2mm_sts_tlast, s2mm_sts_tvalid, s2mm_sts_tready;

    always #5 clk = ~clk;

    axi_datamover_write_ctrl #(
        .S2MM_DATA_WIDTH (DW),
        .S2MM_CMD_WIDTH  (72),
        .S2MM_ADDR_WIDTH (32),
        .S2MM_SIZE_WIDTH (16),
        .S2MM_STS_WIDTH  (8),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ddr_wreq_ready  (ddr_wreq_ready),
        .ddr_wreq_valid  (ddr_wreq_valid),
        .ddr_wreq_addr   (ddr_wreq_addr),
        .ddr_wreq_size   (ddr_wreq_size),
        .ddr_wdata_ready (ddr_wdata_ready),
        .ddr_wdata_valid (ddr_wdata_valid),
        .ddr_wdata       (ddr_wdata),
        .ddr_wresp_valid (ddr_wresp_valid),
        .ddr_wresp       (ddr_wresp),
        .s2mm_cmd_tdata  (s2mm_cmd_tdata),
        .s2mm_cmd_tvalid (s2mm_cmd_tvalid),
        .s2mm_cmd_tready (s2mm_cmd_tready),
        .s2mm_tdata      (s2mm_tdata),
        .s2mm_tkeep      (s2mm_tkeep),
        .s2mm_tlast      (s2mm_tlast),
        .s2mm_tvalid     (s2mm_tvalid),
        .s2mm_tready     (s2mm_tready),
        .s2mm_sts_tdata  (s2mm_sts_tdata),
        .s2mm_sts_tkeep  (s2mm_sts_tkeep),
        .s2mm_sts_tlast  (s2mm_sts_tlast),
        .s2mm_sts_tvalid (s2mm_sts_tvalid),
        .s2mm_sts_tready (s2mm_sts_tready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level expectations, advanced from observed handshakes.
    bit          m_req_rdy, m_boot, m_cmd_vld, m_sts_wait, m_resp_due;
    logic [71:0] m_cmd;
    int          m_pend_beats, m_beats_left, m_to;
    logic [7:0]  m_last_keep;
    logic [1:0]  m_resp, m_last_resp;
    logic [3:0]  m_tag;

    int          obs_cmd_cnt = 0, obs_beats = 0, obs_tlast = 0, obs_resp_cnt = 0;
    logic [71:0] obs_cmd = '0;
    logic [7:0]  obs_keep = '0;
    logic [1:0]  obs_resp = '0;

    function automatic logic [1:0] exp_resp(input logic [7:0] sts, input logic [3:0] tag);
        if (sts[7] && sts[6:4] == 3'b000 && sts[3:0] == tag) return 2'd0;
        if (sts[5]) return 2'd3;
        return 2'd2;
    endfunction

    always @(negedge clk) begin
        bit ev_req, ev_cmd, ev_beat, ev_sts, was_resp, was_sts;
        int sz;
        if (rst) begin
            chk("reset_outputs", {ddr_wreq_ready, ddr_wdata_ready, ddr_wresp_valid, ddr_wresp,
                s2mm_cmd_tvalid, s2mm_tvalid, s2mm_tlast, s2mm_tkeep, s2mm_sts_tready}, '0);
            m_req_rdy = 0; m_boot = 1; m_cmd_vld = 0; m_sts_wait = 0; m_resp_due = 0;
            m_beats_left = 0; m_last_resp = 0; m_tag = 0; m_to = 0;
        end else begin
            chk("wreq_ready", ddr_wreq_ready, m_req_rdy);
            chk("cmd_tvalid", s2mm_cmd_tvalid, m_cmd_vld);
            if (m_cmd_vld) chk("cmd_tdata", s2mm_cmd_tdata, m_cmd);
            chk("s2mm_tvalid", s2mm_tvalid, (m_beats_left > 0) && ddr_wdata_valid);
            chk("wdata_ready", ddr_wdata_ready, (m_beats_left > 0) && s2mm_tready);
            if ((m_beats_left > 0) && ddr_wdata_valid) begin
                chk("tdata", s2mm_tdata, ddr_wdata);
                chk("tlast", s2mm_tlast, m_beats_left == 1);
                chk("tkeep", s2mm_tkeep, (m_beats_left == 1) ? m_last_keep : 8'hFF);
            end
            chk("sts_tready", s2mm_sts_tready, m_sts_wait);
            chk("wresp_valid", ddr_wresp_valid, m_resp_due);
            chk("wresp", ddr_wresp, m_resp_due ? m_resp : m_last_resp);

            if (s2mm_cmd_tvalid && s2mm_cmd_tready) begin
                obs_cmd = s2mm_cmd_tdata; obs_cmd_cnt++;
            end
            if (s2mm_tvalid && s2mm_tready) begin
                obs_beats++;
                if (s2mm_tlast) begin obs_tlast++; obs_keep = s2mm_tkeep; end
            end
            if (ddr_wresp_valid) begin obs_resp = ddr_wresp; obs_resp_cnt++; end

            ev_req   = m_req_rdy && ddr_wreq_valid;
            ev_cmd   = m_cmd_vld && s2mm_cmd_tready;
            ev_beat  = (m_beats_left > 0) && ddr_wdata_valid && s2mm_tready;
            ev_sts   = m_sts_wait && s2mm_sts_tvalid;
            was_resp = m_resp_due;
            was_sts  = m_sts_wait;

            if (m_boot) begin m_req_rdy = 1; m_boot = 0; end
            m_resp_due = 0;
            if (was_resp) begin m_req_rdy = 1; m_tag = m_tag + 4'd1; end
            if (ev_req) begin
                m_req_rdy = 0;
                sz = int'(ddr_wreq_size);
                if (sz == 0) begin
                    m_resp_due = 1; m_resp = 2'd2; m_last_resp = 2'd2;
                end else begin
                    m_cmd_vld = 1;
                    m_cmd = {4'h0, m_tag, 32'(ddr_wreq_addr - (ddr_wreq_addr % 32'(BYTES))),
                             1'b0, 1'b1, 6'h0, 1'b1, 23'(sz)};
                    m_pend_beats = (sz + BYTES - 1) / BYTES;
                    m_last_keep = (sz % BYTES == 0) ? 8'hFF : 8'((1 << (sz % BYTES)) - 1);
                end
            end
            if (ev_cmd) begin m_cmd_vld = 0; m_beats_left = m_pend_beats; end
            if (ev_beat) begin
                m_beats_left--;
                if (m_beats_left == 0) begin m_sts_wait = 1; m_to = 0; end
            end
            if (ev_sts) begin
                m_sts_wait = 0; m_resp_due = 1;
                m_resp = exp_resp(s2mm_sts_tdata, m_tag); m_last_resp = m_resp;
            end
`ifdef DATAMOVER_WR_TIMEOUT_EN
            else if (was_sts) begin
                m_to++;
                if (m_to == TO) begin
                    m_sts_wait = 0; m_resp_due = 1; m_resp = 2'd2; m_last_resp = 2'd2;
                end
            end
`endif
        end
    end

    logic [3:0] tb_tag = '0;
    int d_cmd, d_beats, d_tlast;

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input logic [31:0] addr, input int size, input logic [7:0] sts,
                           input bit early, input bit bp, input bit no_sts);
        int c0, b0, l0, r0, n, sent, beats;
        bit hs;
        c0 = obs_cmd_cnt; b0 = obs_beats; l0 = obs_tlast; r0 = obs_resp_cnt;
        if (early) begin s2mm_sts_tdata = sts; s2mm_sts_tvalid = 1'b1; end
        ddr_wreq_addr = addr; ddr_wreq_size = 16'(size); ddr_wreq_valid = 1'b1;
        hs = 0;
        for (n = 0; n < 50 && !hs; n++) begin
            @(negedge clk); hs = ddr_wreq_ready; cyc();
        end
        ddr_wreq_valid = 1'b0;
        chk("req_accept", hs, 1'b1);
        if (size != 0) begin
            hs = 0;
            for (n = 0; n < 200 && !hs; n++) begin
                s2mm_cmd_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk); hs = s2mm_cmd_tvalid && s2mm_cmd_tready; cyc();
            end
            s2mm_cmd_tready = 1'b0;
            chk("cmd_accept", hs, 1'b1);
            beats = (size + BYTES - 1) / BYTES;
            sent = 0;
            ddr_wdata = {$urandom, $urandom};
            for (n = 0; n < beats * 20 + 20 && sent < beats; n++) begin
                ddr_wdata_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                s2mm_tready     = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                @(negedge clk); hs = ddr_wdata_valid && ddr_wdata_ready; cyc();
                if (hs) begin sent++; ddr_wdata = {$urandom, $urandom}; end
            end
            ddr_wdata_valid = 1'b0; s2mm_tready = 1'b0;
            chk("data_done", 72'(sent), 72'(beats));
            if (!no_sts) begin
                if (!early) repeat ($urandom_range(0, 3)) cyc();
                s2mm_sts_tdata = sts; s2mm_sts_tvalid = 1'b1;
                hs = 0;
                for (n = 0; n < 50 && !hs; n++) begin
                    @(negedge clk); hs = s2mm_sts_tready; cyc();
                end
                chk("sts_accept", hs, 1'b1);
            end
        end
        s2mm_sts_tvalid = 1'b0;
        for (n = 0; n < 60 && obs_resp_cnt == r0; n++) cyc();
        chk("resp_seen", 72'(obs_resp_cnt - r0), 72'd1);
        tb_tag = tb_tag + 4'd1;
        d_cmd = obs_cmd_cnt - c0; d_beats = obs_beats - b0; d_tlast = obs_tlast - l0;
    endtask

    task automatic reset_mid_data();
        int n;
        bit hs;
        ddr_wreq_addr = 32'h4000_0000; ddr_wreq_size = 16'd40; ddr_wreq_valid = 1'b1;
        hs = 0;
        for (n = 0; n < 50 && !hs; n++) begin
            @(negedge clk); hs = ddr_wreq_ready; cyc();
        end
        ddr_wreq_valid = 1'b0;
        s2mm_cmd_tready = 1'b1;
        cyc();
        s2mm_cmd_tready = 1'b0;
        ddr_wdata = 64'h1111_2222_3333_4444; ddr_wdata_valid = 1'b1; s2mm_tready = 1'b1;
        repeat (2) cyc();
        #2 rst = 1'b1;
        #1 chk("rst_mid_data", {s2mm_tvalid, s2mm_cmd_tvalid, ddr_wreq_ready, ddr_wdata_ready,
                                 s2mm_sts_tready, ddr_wresp_valid, s2mm_tlast}, '0);
        ddr_wdata_valid = 1'b0; s2mm_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tb_tag = '0;
    endtask

    initial begin
        int sz;
        logic [7:0] st;
        rst = 1'b1;
        ddr_wreq_valid = 0; ddr_wreq_addr = 0; ddr_wreq_size = 0;
        ddr_wdata_valid = 0; ddr_wdata = 0;
        s2mm_cmd_tready = 0; s2mm_tready = 0;
        s2mm_sts_tdata = 0; s2mm_sts_tkeep = 1'b1; s2mm_sts_tlast = 1'b1; s2mm_sts_tvalid = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_txn(32'h1000_0007, 64, 8'h80, 0, 0, 0);
        chk("cmd_64", obs_cmd, 72'h00_1000_0000_4080_0040);
        chk("beats_64", 72'(d_beats), 72'd8);
        chk("tlast_64", 72'(d_tlast), 72'd1);
        chk("keep_64", obs_keep, 8'hFF);
        chk("resp_64", obs_resp, 2'd0);

        run_txn(32'h2000_0010, 13, 8'h81, 0, 0, 0);
        chk("cmd_13", obs_cmd, 72'h01_2000_0010_4080_000D);
        chk("beats_13", 72'(d_beats), 72'd2);
        chk("keep_13", obs_keep, 8'h1F);
        chk("resp_13", obs_resp, 2'd0);

        run_txn(32'h2000_0100, 0, 8'h80, 0, 0, 0);
        chk("cmd_size0", 72'(d_cmd), 72'd0);
        chk("resp_size0", obs_resp, 2'd2);

        run_txn(32'h0000_0040, 8, 8'hA0, 0, 0, 0);
        chk("resp_decerr", obs_resp, 2'd3);
        run_txn(32'h0000_0080, 8, 8'hC0, 1, 0, 0);
        chk("resp_slverr", obs_resp, 2'd2);

        reset_mid_data();
        run_txn(32'h5000_0000, 24, 8'h85, 0, 0, 0);
        chk("cmd_tag_after_rst", obs_cmd[67:64], 4'h0);
        chk("resp_tag_mismatch", obs_resp, 2'd2);

        for (int i = 0; i < 40; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 72));
            case ($urandom_range(0, 6))
                0, 1, 2: st = {4'h8, tb_tag};
                3:       st = {4'h8, tb_tag + 4'd1};
                4:       st = {4'hA, tb_tag};
                5:       st = {4'hC, tb_tag};
                default: st = {4'h9, tb_tag};
            endcase
            run_txn($urandom, sz, st, $urandom_range(0, 4) == 0, 1, 0);
        end

`ifdef DATAMOVER_WR_TIMEOUT_EN
        run_txn(32'h3000_0000, 8, 8'h80, 0, 0, 1);
        chk("resp_timeout", obs_resp, 2'd2);
        run_txn(32'h3000_0100, 16, {4'h8, tb_tag}, 0, 0, 0);
        chk("resp_after_timeout", obs_resp, 2'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_datamover_write_ctrl.md
# axi_datamover_write_ctrl

Write-side companion of the DDR read path: converts a DDR write request (address + byte count) and a plain write-data stream into an AXI DataMover S2MM command, an S2MM AXI4-Stream with generated `tkeep`/`tlast`, and a single write response decoded from the S2MM status stream. Sits between DDR write clients and the DataMover S2MM channel. One transfer in flight at a time.

## Interface
- `S2MM_DATA_WIDTH`, 64, data/stream width in bits (multiple of 8); `BYTES = S2MM_DATA_WIDTH/8`
- `S2MM_CMD_WIDTH`, 72, command width
- `S2MM_ADDR_WIDTH`, 32, address width
- `S2MM_SIZE_WIDTH`, 16, request byte-count width (≤ 23)
- `S2MM_STS_WIDTH`, 8, status width
- `TIMEOUT_CYCLES`, 65535, status watchdog limit (only with macro)

Ports:
- `clk` in 1 — single clock
- `rst` in 1 — asynchronous, active-high reset
- `ddr_wreq_ready` out 1 / `ddr_wreq_valid` in 1 — request handshake
- `ddr_wreq_addr` in S2MM_ADDR_WIDTH — start byte address
- `ddr_wreq_size` in S2MM_SIZE_WIDTH — bytes to write
- `ddr_wdata_ready` out 1 / `ddr_wdata_valid` in 1 / `ddr_wdata` in S2MM_DATA_WIDTH — write data
- `ddr_wresp_valid` out 1 — one-cycle response pulse
- `ddr_wresp` out 2 — 0 OKAY, 2 SLVERR, 3 DECERR
- `s2mm_cmd_tdata` out S2MM_CMD_WIDTH / `s2mm_cmd_tvalid` out 1 / `s2mm_cmd_tready` in 1
- `s2mm_tdata` out S2MM_DATA_WIDTH / `s2mm_tkeep` out BYTES / `s2mm_tlast` out 1 / `s2mm_tvalid` out 1 / `s2mm_tready` in 1
- `s2mm_sts_tdata` in S2MM_STS_WIDTH / `s2mm_sts_tkeep` in S2MM_STS_WIDTH/8 / `s2mm_sts_tlast` in 1 / `s2mm_sts_tvalid` in 1 / `s2mm_sts_tready` out 1

## Operation
- FSM states: IDLE, CMD, DATA, STS, RESP.
- IDLE: `ddr_wreq_ready`=1. On valid&ready latch addr, size; compute `beats = ceil(size/BYTES)`, `last_keep = (size % BYTES == 0) ? all-ones : (1<<(size % BYTES))-1`. size==0 → RESP with `ddr_wresp`=2, no command issued. Else → CMD.
- CMD: `s2mm_cmd_tvalid`=1, `s2mm_cmd_tdata` = {rsv 4'h0, tag, addr, drr 0, eof 1, dsa 6'h0, type 1, btt = zero-extended size to 23 bits}; addr low log2(BYTES) bits forced to 0. Hold stable until `s2mm_cmd_tready` → DATA.
- DATA: combinational pass-through: `s2mm_tvalid`=`ddr_wdata_valid`, `ddr_wdata_ready`=`s2mm_tready`, `s2mm_tdata`=`ddr_wdata`. Beat counter decrements per handshake; `s2mm_tlast`=1 and `s2mm_tkeep`=`last_keep` when counter==1, else tkeep all-ones. Last handshake → STS.
- STS: `s2mm_sts_tready`=1. On `s2mm_sts_tvalid`: decode — bit7 OKAY & bits6:4 zero & tag[3:0] match → 0; bit5 DECERR → 3; otherwise (SLVERR, INTERR, tag mismatch) → 2. → RESP.
- RESP: `ddr_wresp_valid`=1 for exactly one cycle; tag increments (4-bit, wraps 15→0); → IDLE.
- Outside their states: `ddr_wreq_ready`, `ddr_wdata_ready`, `s2mm_tvalid`, `s2mm_cmd_tvalid`, `s2mm_sts_tready` all 0. Status beats arriving outside STS are not consumed.

## Timing
- Reset: state IDLE, tag 0, all outputs 0 (`ddr_wreq_ready` becomes 1 first cycle after reset release).
- Request accepted in cycle N → `s2mm_cmd_tvalid` high at N+1.
- Data path zero latency; full throughput while both sides ready.
- Status accepted in cycle M → `ddr_wresp_valid` at M+1; `ddr_wreq_ready` at M+2.
- `ddr_wresp` holds value until next response.
- Reset mid-transfer: immediate return to IDLE, partial stream abandoned, no response.

## Configuration
- `DATAMOVER_WR_TIMEOUT_EN` defined: counter runs in STS; reaching `TIMEOUT_CYCLES` with no status → RESP with `ddr_wresp`=2; counter clears on STS entry.
- Undefined: STS waits indefinitely; `TIMEOUT_CYCLES` unused, no counter logic.

## Structure
- Package `axi_datamover_pkg`: state enum, response codes (OKAY/SLVERR/DECERR), status bit positions, command field widths and type/eof constants.
- Sub-module `axi_datamover_keep_gen`: registered beat count and `last_keep` from size.

## Test plan
- size=64, BYTES=8 → cmd btt=64, eof=1, tag 0; 8 beats, tlast on 8th, tkeep 8'hFF; status 8'h80 → resp 0.
- size=13 → 2 beats, last tkeep 8'h1F; status 8'h81 with tag 1 → resp 0.
- size=0 → no cmd, resp pulse with 2, ready again 2 cycles later.
- status 8'hA0 → resp 3; 8'hC0 → resp 2; tag mismatch 8'h85 with tag 0 → resp 2.
- Random backpressure on cmd/data tready → command stable, no beats lost or duplicated, tlast count exact.
- With `DATAMOVER_WR_TIMEOUT_EN`, TIMEOUT_CYCLES=16, no status → resp 2 after 16 cycles; rst asserted mid-DATA → all valids low, IDLE.
